// File: rtl/npu_layer_sequencer.sv
// npu_layer_sequencer
//   Runs one NPU layer: for each neuron n it selects weight bank n, starts the
//   dot-product unit on the latched activation vector, waits for the result
//   (with a hang timeout) and writes the result to the result buffer at n.
//
// Parameters
//   NUM_NEURONS  neurons per layer, one weight bank each (1..4)
//   TIMEOUT      WAIT cycles without dp_done before the layer is aborted
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start, in_data     host request and activation vector (sampled in IDLE)
//   busy, done, err    status: not-idle, one-cycle completion, sticky timeout
//   bank_sel           weight ROM bank index (current neuron)
//   dp_data, dp_start  activation vector and start pulse to the dot-product unit
//   dp_done, dp_result dot-product completion strobe and result
//   res_we, res_addr,
//   res_data           result buffer write port
//
// Build option
//   NPU_SEQ_RELU_EN    when defined, negative results are written as zero
module npu_layer_sequencer #(
  parameter int NUM_NEURONS = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] in_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  bank_sel,
  output logic [63:0] dp_data,
  output logic        dp_start,
  input  logic        dp_done,
  input  logic [15:0] dp_result,
  output logic        res_we,
  output logic [1:0]  res_addr,
  output logic [15:0] res_data
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      n;
  logic [CW-1:0]   tmo_cnt;
  logic            last_n;
  logic            tmo_last;
  logic [15:0]     result_proc;

  assign last_n   = (n == 2'(NUM_NEURONS - 1));
  // This WAIT cycle is the TIMEOUT-th one; the counter reaches TIMEOUT here.
  assign tmo_last = (tmo_cnt == CW'(TIMEOUT - 1));

  // The bank index and the result address both track the neuron counter,
  // which only moves on the STORE->SETUP transition.
  assign bank_sel = n;
  assign res_addr = n;

`ifdef NPU_SEQ_RELU_EN
  assign result_proc = dp_result[15] ? '0 : dp_result;
`else
  assign result_proc = dp_result;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      n        <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
      dp_data  <= '0;
      res_data <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            dp_data <= in_data;
            n       <= '0;
            err     <= 1'b0;
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          // dp_done takes priority over a coinciding timeout.
          if (dp_done) begin
            res_data <= result_proc;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
            if (tmo_last) err <= 1'b1;
          end
        end
        STORE: begin
          if (!last_n) n <= n + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    dp_start  = 1'b0;
    res_we    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP: state_nxt = ISSUE;
      ISSUE: begin
        dp_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (dp_done)       state_nxt = STORE;
        else if (tmo_last) state_nxt = DONE;
      end
      STORE: begin
        res_we    = 1'b1;
        state_nxt = last_n ? DONE : SETUP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_npu_layer_sequencer.sv
// tb_npu_layer_sequencer
//   Self-checking bench for npu_layer_sequencer with default parameters.
//   A layer is described by a per-neuron dot-product latency and result; the
//   expected write list, completion cycle and error flag are derived from
//   those by cycle arithmetic and compared with what the DUT produced.
module tb_npu_layer_sequencer;

  localparam int NN     = 3;
  localparam int TMO    = 255;
  localparam int BUDGET = 2000;
  localparam int NEVER  = 9999;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] in_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  bank_sel;
  logic [63:0] dp_data;
  logic        dp_start;
  logic        dp_done;
  logic [15:0] dp_result;
  logic        res_we;
  logic [1:0]  res_addr;
  logic [15:0] res_data;

  always #5 clk = ~clk;

  npu_layer_sequencer #(.NUM_NEURONS(NN), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .busy(busy), .done(done), .err(err), .bank_sel(bank_sel),
    .dp_data(dp_data), .dp_start(dp_start), .dp_done(dp_done),
    .dp_result(dp_result), .res_we(res_we), .res_addr(res_addr),
    .res_data(res_data)
  );

  int total = 0;
  int bad   = 0;

  // Stimulus description: dly[i] = WAIT cycles before dp_done for neuron i.
  int          dly [NN];
  logic [15:0] rv  [NN];

  int          obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_bank[$];
  int          done_cnt;
  int          done_cyc;
  logic        viol;

  int          exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_done;
  logic        exp_err;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef NPU_SEQ_RELU_EN
    if ($signed(v) < 0) return 16'h0000;
`endif
    return v;
  endfunction

  // Each completed neuron costs SETUP + ISSUE + (dly+1) WAIT + STORE cycles;
  // a hung neuron costs SETUP + ISSUE + TMO WAIT cycles and aborts the layer.
  function automatic void model();
    int t = 0;
    exp_addr.delete();
    exp_data.delete();
    exp_err = 1'b0;
    for (int i = 0; i < NN; i++) begin
      if (dly[i] >= TMO) begin
        t += 2 + TMO;
        exp_err = 1'b1;
        break;
      end
      t += dly[i] + 4;
      exp_addr.push_back(i);
      exp_data.push_back(relu(rv[i]));
    end
    exp_done = t + 1;
  endfunction

  task automatic run_layer(input logic [63:0] val, input bit noise, input int stop_at);
    int cyc    = 0;
    int issues = 0;
    int target = -1;
    int tail   = -1;
    obs_addr.delete();
    obs_data.delete();
    obs_bank.delete();
    done_cnt = 0;
    done_cyc = -1;
    viol     = 1'b0;
    start    = 1'b1;
    in_data  = val;
    dp_done  = 1'b0;
    while (cyc < BUDGET) begin
      tick();
      cyc++;
      start     = 1'b0;
      dp_done   = 1'b0;
      dp_result = 16'($urandom);
      if (cyc == stop_at) return;
      if (busy && dp_data !== val) viol = 1'b1;
      if (int'(dp_start) + int'(res_we) + int'(done) > 1) viol = 1'b1;
      if (dp_start) begin
        obs_bank.push_back(int'(bank_sel));
        target = (issues < NN) ? cyc + 1 + dly[issues] : -1;
        issues++;
      end
      if (res_we) begin
        obs_addr.push_back(int'(res_addr));
        obs_data.push_back(res_data);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          tail     = cyc + 3;
        end
      end
      if (cyc == target) begin
        dp_done   = 1'b1;
        dp_result = rv[issues-1];
      end else if (noise && (dp_start || res_we)) begin
        dp_done = 1'b1;
      end
      if (noise && busy && !done && $urandom_range(0, 3) == 0) begin
        start   = 1'b1;
        in_data = 64'h1234;
      end
      if (cyc == tail) return;
    end
  endtask

  task automatic verify(input string tag);
    int nw;
    model();
    check({tag, ":done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, ":done_count"}, 64'(done_cnt), 64'd1);
    check({tag, ":err"}, 64'(err), 64'(exp_err));
    check({tag, ":writes"}, 64'(obs_addr.size()), 64'(exp_addr.size()));
    nw = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < nw; i++) begin
      check({tag, ":addr"}, 64'(obs_addr[i]), 64'(exp_addr[i]));
      check({tag, ":data"}, 64'(obs_data[i]), 64'(exp_data[i]));
    end
    check({tag, ":issues"}, 64'(obs_bank.size()), 64'(exp_addr.size() + int'(exp_err)));
    foreach (obs_bank[i]) check({tag, ":bank"}, 64'(obs_bank[i]), 64'(i));
    check({tag, ":cycle_rules"}, 64'(viol), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":busy"}, 64'(busy), 64'd0);
    check({tag, ":done"}, 64'(done), 64'd0);
    check({tag, ":err"}, 64'(err), 64'd0);
    check({tag, ":bank_sel"}, 64'(bank_sel), 64'd0);
    check({tag, ":dp_data"}, dp_data, 64'd0);
    check({tag, ":dp_start"}, 64'(dp_start), 64'd0);
    check({tag, ":res_we"}, 64'(res_we), 64'd0);
    check({tag, ":res_addr"}, 64'(res_addr), 64'd0);
    check({tag, ":res_data"}, 64'(res_data), 64'd0);
  endtask

  // Reset with every other input pushing the FSM forward; afterwards the
  // sequencer must sit idle with no write or completion leaking out.
  task automatic reset_midrun(input string tag);
    logic quiet = 1'b1;
    reset     = 1'b1;
    start     = 1'b1;
    dp_done   = 1'b1;
    dp_result = 16'h7777;
    tick();
    check_reset_outputs(tag);
    reset   = 1'b0;
    start   = 1'b0;
    dp_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_we || done || busy) quiet = 1'b0;
    end
    check({tag, ":quiet_after"}, 64'(quiet), 64'd1);
  endtask

  task automatic set_layer(input int d0, input int d1, input int d2,
                           input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    rv[0]  = r0; rv[1]  = r1; rv[2]  = r2;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_data   = '0;
    dp_done   = 1'b0;
    dp_result = '0;
    tick(); tick(); tick();
    check_reset_outputs("por");
    reset = 1'b0;
    tick();

    // Nominal layer: one-cycle dot products.
    set_layer(0, 0, 0, 16'h0010, 16'h0020, 16'h0030);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, -1);
    verify("nominal");
    check("nominal:latency", 64'(done_cyc), 64'(4 * NN + 1));

    // Negative result: clamped only in the ReLU build.
    set_layer(0, 0, 0, 16'hFFF0, 16'h0020, 16'h8000);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, -1);
    verify("negative");
`ifdef NPU_SEQ_RELU_EN
    if (obs_data.size() > 0) check("negative:relu", 64'(obs_data[0]), 64'h0000);
`else
    if (obs_data.size() > 0) check("negative:raw", 64'(obs_data[0]), 64'hFFF0);
`endif

    // Neuron 1 hangs: timeout aborts the layer after one write.
    set_layer(0, NEVER, 0, 16'h0111, 16'h0222, 16'h0333);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, -1);
    verify("hang");

    // Start pulses and stray dp_done while busy must be ignored; err clears.
    set_layer(1, 0, 2, 16'h1111, 16'h2222, 16'h3333);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b1, -1);
    verify("noise");

    // dp_done on the last allowed WAIT cycle wins over the timeout.
    set_layer(0, TMO - 1, 0, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    run_layer(64'h0123_4567_89AB_CDEF, 1'b0, -1);
    verify("edge_win");

    // dp_done one cycle too late lands in DONE and is ignored.
    set_layer(0, TMO, 0, 16'h0A0A, 16'h0B0B, 16'h0C0C);
    run_layer(64'h0123_4567_89AB_CDEF, 1'b0, -1);
    verify("edge_late");

    // Randomized layers.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NN; i++) begin
        int r = $urandom_range(0, 11);
        if (r < 9)       dly[i] = $urandom_range(0, 4);
        else if (r == 9) dly[i] = TMO - 1;
        else if (r == 10) dly[i] = TMO;
        else             dly[i] = NEVER;
        rv[i] = 16'($urandom);
      end
      run_layer({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1);
      verify("random");
    end

    // Reset in WAIT of neuron 1, then a clean run from neuron 0.
    set_layer(0, 20, 0, 16'h0101, 16'h0202, 16'h0303);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 9);
    reset_midrun("rst_wait");
    set_layer(0, 0, 0, 16'h0044, 16'h0055, 16'h0066);
    run_layer(64'h5555_5555_5555_5555, 1'b0, -1);
    verify("after_rst_wait");

    // Reset in the final STORE: the pending done must not appear.
    set_layer(0, 0, 0, 16'h0101, 16'h0202, 16'h0303);
    run_layer(64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 12);
    check("rst_store:in_store", 64'(res_we), 64'd1);
    reset_midrun("rst_store");
    set_layer(2, 1, 0, 16'h7FFF, 16'h8001, 16'h0000);
    run_layer(64'hFFFF_0000_FFFF_0000, 1'b0, -1);
    verify("after_rst_store");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npu_layer_sequencer.md
NPU_LAYER_SEQUENCER -- requirements
Module: npu_layer_sequencer

Interface
REQ-001 Parameter NUM_NEURONS, default 3; neurons per layer, one weight bank each; legal range 1..4.
REQ-002 Parameter TIMEOUT, default 255; maximum WAIT cycles before a dot-product is declared hung.
REQ-003 Port clk, in, 1; the single clock, all logic on its rising edge.
REQ-004 Port reset, in, 1; synchronous, active-high.
REQ-005 Port start, in, 1; host request to run one layer; sampled only in IDLE.
REQ-006 Port in_data, in, 64; input activation vector; latched when start is accepted.
REQ-007 Port busy, out, 1; high in every state except IDLE.
REQ-008 Port done, out, 1; one-cycle completion pulse.
REQ-009 Port err, out, 1; sticky timeout flag.
REQ-010 Port bank_sel, out, 2; weight ROM bank index (64 weights per bank).
REQ-011 Port dp_data, out, 64; activation vector to the dot-product unit.
REQ-012 Port dp_start, out, 1; one-cycle dot-product start pulse.
REQ-013 Port dp_done, in, 1; dot-product completion strobe.
REQ-014 Port dp_result, in, 16; dot-product result, two's complement, valid with dp_done.
REQ-015 Port res_we, out, 1; result buffer write enable.
REQ-016 Port res_addr, out, 2; result buffer address, equal to the neuron index.
REQ-017 Port res_data, out, 16; result buffer write data.

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, ISSUE, WAIT, STORE and DONE, one-hot or binary.
REQ-019 IDLE: when start=1, latch in_data into dp_data, clear the neuron counter n and clear err, then go to SETUP.
REQ-020 SETUP: drive bank_sel=n for one cycle to cover the registered ROM read, then go to ISSUE.
REQ-021 ISSUE: dp_start=1 for exactly this cycle, clear the timeout counter, then go to WAIT.
REQ-022 WAIT: on dp_done=1, register dp_result and go to STORE; otherwise increment the timeout counter.
REQ-023 WAIT timeout: when the counter reaches TIMEOUT without dp_done, set err=1 and go to DONE, skipping the remaining neurons.
REQ-024 dp_done in the same cycle the counter reaches TIMEOUT: dp_done wins and err stays 0.
REQ-025 STORE: res_we=1, res_addr=n, res_data=processed result; if n==NUM_NEURONS-1 go to DONE, else n+1 and go to SETUP.
REQ-026 DONE: done=1 for one cycle, then go to IDLE.
REQ-027 bank_sel SHALL hold n from SETUP through STORE; dp_data SHALL be stable from acceptance until IDLE.
REQ-028 start while busy=1 SHALL be ignored; dp_done outside WAIT SHALL be ignored.
REQ-029 Latency: with dp_done in the first WAIT cycle and start accepted in cycle 0, done SHALL assert in cycle 4*NUM_NEURONS+1.
REQ-030 res_we, dp_start and done SHALL never be high in the same cycle.

Reset
REQ-031 Reset SHALL be synchronous and active-high, and SHALL override all other inputs, including mid-operation.
REQ-032 Reset values: state=IDLE, n=0, timeout counter=0.
REQ-033 Output reset values: busy=0, done=0, err=0, bank_sel=0, dp_data=0, dp_start=0, res_we=0, res_addr=0, res_data=0.
REQ-034 Reset asserted during WAIT or STORE SHALL suppress any pending res_we and done.

Configuration
REQ-035 Macro NPU_SEQ_RELU_EN: when defined, res_data SHALL be 16'h0000 if dp_result[15]=1, else dp_result.
REQ-036 When NPU_SEQ_RELU_EN is undefined, res_data SHALL equal dp_result unmodified, with identical timing.

Verification
REQ-037 Default parameters; start with in_data=64'hAAAA_AAAA_AAAA_AAAA; dp_done one cycle after each dp_start with results 16'h0010/16'h0020/16'h0030 -> writes to addresses 0/1/2 with those values; bank_sel steps 0,1,2; done in cycle 13; err=0.
REQ-038 Macro defined, dp_result=16'hFFF0 -> res_data=16'h0000; macro undefined, same stimulus -> res_data=16'hFFF0.
REQ-039 dp_done withheld for neuron 1 -> err=1 after 255 WAIT cycles; done pulses once; only address 0 is written.
REQ-040 start pulsed again mid-run with in_data=64'h1234 -> ignored; dp_data stays AAAA_AAAA_AAAA_AAAA; exactly one done.
REQ-041 reset asserted in WAIT of neuron 1 -> next cycle all outputs at reset values and no further res_we; a new start runs cleanly from n=0.
REQ-042 dp_done asserted in the same cycle the timeout counter reaches 255 -> STORE taken, err=0.
